ltssm_ctrl: RTL

Parametrised link training state machine: successor to the fixed-pattern, single-beat LTSSM in the PCIe training path. Sits between the lane deserialiser and link-layer enable. Adds:
- data width and training-pattern widths as parameters;
- N-consecutive-match qualification of training words;
- per-state timeouts back to DETECT;
- a forced link-down path;
- an L0 ↔ RECOVERY retrain loop with a saturating recovery counter.

---
 rtl/ltssm_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ltssm_ctrl.sv
// ltssm_ctrl: parametrised link training state machine.
// Walks DETECT -> POLLING -> CONFIG -> L0. Each training step is qualified by
// MATCH_CNT consecutive matching valid words. Timed states fall back to
// DETECT after TIMEOUT_CYC cycles. L0 <-> RECOVERY forms a retrain loop, and
// each L0 -> RECOVERY entry is counted in a saturating counter.
//
// Ports:
//   clk          clock; all logic runs on the rising edge
//   rst_n        asynchronous active-low reset
//   valid        qualifier for ts_data
//   ts_data      received training word, DATA_W bits
//   link_down    level input; forces DETECT
//   retrain_req  level input; requests RECOVERY while in L0
//   state        current state encoding (registered)
//   link_up      high exactly while state is L0 (registered)
//   timeout      one-cycle pulse after a timeout transition (registered)
//   recov_cnt    saturating count of L0 -> RECOVERY entries (registered)
module ltssm_ctrl #(
  parameter int DATA_W      = 32,
  parameter int MATCH_CNT   = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] ts_data,
  input  logic              link_down,
  input  logic              retrain_req,
  output logic [3:0]        state,
  output logic              link_up,
  output logic              timeout,
  output logic [RCNT_W-1:0] recov_cnt
);

  typedef enum logic [3:0] {
    DETECT              = 4'd0,
    POLLING_ACTIVE      = 4'd1,
    POLLING_CONFIG      = 4'd2,
    CONFIG_LANENUM_WAIT = 4'd3,
    CONFIG_COMPLETE     = 4'd4,
    CONFIG_IDLE         = 4'd5,
    L0                  = 4'd6,
    RECOVERY            = 4'd7
  } state_e;

  localparam int MC_W = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;
  localparam int TC_W = $clog2(TIMEOUT_CYC);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MATCH_CNT - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYC - 1);

  localparam logic [DATA_W-1:0] P_PA   = {(DATA_W/8){8'hAA}};
  localparam logic [DATA_W-1:0] P_PC   = {(DATA_W/8){8'hBB}};
  localparam logic [DATA_W-1:0] P_CFG  = {(DATA_W/8){8'hCC}};
  localparam logic [DATA_W-1:0] P_IDLE = {(DATA_W/8){8'hDD}};
  localparam logic [DATA_W-1:0] P_REC  = {(DATA_W/8){8'hEE}};

  // state_r is kept as a plain 4-bit vector so illegal encodings 8..15 are
  // representable and recovered from.
  logic [3:0]        state_r;
  logic [3:0]        next_s;
  logic [MC_W-1:0]   mcnt_r;
  logic [TC_W-1:0]   tcnt_r;
  logic              link_up_r;
  logic              timeout_r;
  logic [RCNT_W-1:0] recov_cnt_r;

  logic [DATA_W-1:0] exp_pat_s;
  logic              match_s;
  logic              qual_s;
  logic              timed_s;
  logic              tmo_hit_s;
  logic              to_s;
  logic              rinc_s;

  // Expected training pattern for the current state.
  always_comb begin
    exp_pat_s = {DATA_W{1'b0}};
    case (state_r)
      DETECT:         exp_pat_s = P_PA;
      POLLING_ACTIVE: exp_pat_s = P_PC;
      POLLING_CONFIG: exp_pat_s = P_CFG;
      CONFIG_IDLE:    exp_pat_s = P_IDLE;
      L0:             exp_pat_s = P_REC;
      RECOVERY:       exp_pat_s = P_IDLE;
      default:        exp_pat_s = {DATA_W{1'b0}};
    endcase
  end

  assign match_s   = (ts_data == exp_pat_s);
  assign qual_s    = valid && match_s && (mcnt_r == MC_LAST);
  assign timed_s   = (state_r == POLLING_ACTIVE) || (state_r == POLLING_CONFIG) ||
                     (state_r == CONFIG_IDLE)    || (state_r == RECOVERY);
  assign tmo_hit_s = timed_s && (tcnt_r == TC_LAST);

  // Next-state decode. link_down overrides everything, illegal encodings
  // fall into the default arm, and a qualified match beats a timeout.
  always_comb begin
    next_s = state_r;
    to_s   = 1'b0;
    rinc_s = 1'b0;
    if (link_down) begin
      next_s = DETECT;
    end else begin
      case (state_r)
        DETECT: begin
          if (qual_s) next_s = POLLING_ACTIVE;
          else        next_s = DETECT;
        end
        POLLING_ACTIVE: begin
          if (qual_s)         next_s = POLLING_CONFIG;
          else if (tmo_hit_s) begin next_s = DETECT; to_s = 1'b1; end
          else                next_s = POLLING_ACTIVE;
        end
        POLLING_CONFIG: begin
          if (qual_s)         next_s = CONFIG_LANENUM_WAIT;
          else if (tmo_hit_s) begin next_s = DETECT; to_s = 1'b1; end
          else                next_s = POLLING_CONFIG;
        end
        CONFIG_LANENUM_WAIT: next_s = CONFIG_COMPLETE;
        CONFIG_COMPLETE:     next_s = CONFIG_IDLE;
        CONFIG_IDLE: begin
          if (qual_s)         next_s = L0;
          else if (tmo_hit_s) begin next_s = DETECT; to_s = 1'b1; end
          else                next_s = CONFIG_IDLE;
        end
        L0: begin
          // Retrain exit needs only one beat; no MATCH_CNT qualification.
          if (retrain_req || (valid && match_s)) begin
            next_s = RECOVERY;
            rinc_s = 1'b1;
          end else begin
            next_s = L0;
          end
        end
        RECOVERY: begin
          if (qual_s)         next_s = L0;
          else if (tmo_hit_s) begin next_s = DETECT; to_s = 1'b1; end
          else                next_s = RECOVERY;
        end
        default: next_s = DETECT;
      endcase
    end
  end

  // State, match/timeout counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DETECT;
      mcnt_r      <= '0;
      tcnt_r      <= '0;
      link_up_r   <= 1'b0;
      timeout_r   <= 1'b0;
      recov_cnt_r <= '0;
    end else begin
      state_r   <= next_s;
      link_up_r <= (next_s == L0);
      timeout_r <= to_s;

      // link_down also clears the match run while staying in DETECT.
      if (link_down || (next_s != state_r)) mcnt_r <= '0;
      else if (valid && match_s)           mcnt_r <= mcnt_r + MC_W'(1'b1);
      else if (valid)                      mcnt_r <= '0;
      else                                 mcnt_r <= mcnt_r;

      if (link_down || (next_s != state_r)) tcnt_r <= '0;
      else if (timed_s)                    tcnt_r <= tcnt_r + TC_W'(1'b1);
      else                                 tcnt_r <= '0;

      if (rinc_s && (recov_cnt_r != {RCNT_W{1'b1}}))
        recov_cnt_r <= recov_cnt_r + RCNT_W'(1'b1);
      else
        recov_cnt_r <= recov_cnt_r;
    end
  end

  assign state     = state_r;
  assign link_up   = link_up_r;
  assign timeout   = timeout_r;
  assign recov_cnt = recov_cnt_r;

endmodule
